vdf_seq_89: RTL

- Program sequencer for cryptoprocessor_wrapper_89, the 89-bit redundant-form Fp engine.
- Fetches 25-bit instruction words from an internal program RAM and drives the engine's get_output/data_en/ins_in/command/din pins.
- Applies stall-on-hazard scheduling using per-op latency tracking.
- Moves operand data in and result data out through valid/ready streams, so the engine runs an isogeny-step program without host cycle-by-cycle control.

---
 rtl/vdf_seq_89.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/vdf_seq_89.sv
// Program sequencer for the 89-bit redundant-form Fp engine: fetches 25-bit words,
// schedules them around result latency, and streams operands in and results out.
module vdf_seq_89 #(
  parameter int PA       = 8,
  parameter int LAT_ALU  = 1,
  parameter int LAT_MUL  = 1,
  parameter int DOUT_LAT = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           prog_we,
  input  logic [PA-1:0]  prog_addr,
  input  logic [24:0]    prog_data,
  input  logic           start,
  input  logic [PA-1:0]  start_pc,
  output logic           busy,
  output logic           done,
  output logic           err,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [88:0]    in_d1,
  input  logic [88:0]    in_d2,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [88:0]    out_d1,
  output logic [88:0]    out_d2,
  output logic           eng_get_output,
  output logic           eng_data_en,
  output logic           eng_ins_in,
  output logic [23:0]    eng_command,
  output logic [88:0]    eng_din_1,
  output logic [88:0]    eng_din_2,
  input  logic [88:0]    eng_dout_1,
  input  logic [88:0]    eng_dout_2
);

  localparam int DEPTH = (LAT_ALU > LAT_MUL) ? LAT_ALU : LAT_MUL;
  localparam logic [3:0] ALU_CNT = 4'(LAT_ALU - 1);
  localparam logic [3:0] MUL_CNT = 4'(LAT_MUL - 1);
  localparam logic [2:0] RD_CNT  = 3'(DOUT_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_WAIT_IN, S_READ_WAIT, S_OUT_HOLD
  } state_t;

  state_t        state;
  logic [24:0]   prog_mem [2**PA];
  logic [24:0]   instr;
  logic [PA-1:0] pc;
  logic [2:0]    rd_cnt;

  logic [DEPTH-1:0]      trk_vld;
  logic [DEPTH-1:0][6:0] trk_dst;
  logic [DEPTH-1:0][3:0] trk_cnt;

  logic       out_flag, is_read, is_load, is_copy, is_alu3, is_mul, is_halt;
  logic       use_s1, use_s2, use_dst, hazard;
  logic [2:0] opcode;
  logic [6:0] src1, src2, dst;
  logic       issue_ok, exec_op, load_fire, adv, pc_last;
  logic       push_en;
  logic [3:0] push_cnt;

  assign out_flag = instr[24];
  assign opcode   = instr[23:21];
  assign src1     = instr[20:14];
  assign src2     = instr[13:7];
  assign dst      = instr[6:0];

  assign is_read = out_flag;
  assign is_load = !out_flag && (opcode == 3'd1);
  assign is_copy = !out_flag && (opcode == 3'd2);
  assign is_alu3 = !out_flag && (opcode == 3'd3 || opcode == 3'd4 || opcode == 3'd5);
  assign is_mul  = !out_flag && (opcode == 3'd5);
  assign is_halt = !out_flag && (opcode == 3'd7);

  assign use_s1  = is_read | is_copy | is_alu3;
  assign use_s2  = is_alu3;
  assign use_dst = is_load | is_copy | is_alu3;

  always_comb begin
    hazard = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (trk_vld[i] && ((use_s1  && trk_dst[i] == src1) ||
                         (use_s2  && trk_dst[i] == src2) ||
                         (use_dst && trk_dst[i] == dst)))
        hazard = 1'b1;
    end
  end

  assign issue_ok  = (state == S_ISSUE) && !hazard;
  assign exec_op   = issue_ok && (is_copy || is_alu3);
  assign load_fire = (state == S_WAIT_IN) && in_valid;
  assign pc_last   = (pc == '1);
  assign adv       = (issue_ok && !is_read && !is_halt && !is_load) || load_fire ||
                     ((state == S_OUT_HOLD) && out_ready);

  assign push_cnt = (exec_op && is_mul) ? MUL_CNT : ALU_CNT;
  assign push_en  = (exec_op || load_fire) && (push_cnt != 4'd0);

  assign busy           = (state != S_IDLE);
  assign in_ready       = load_fire;
  assign eng_data_en    = load_fire;
  assign eng_ins_in     = exec_op || load_fire;
  assign eng_get_output = issue_ok && is_read;
  assign eng_command    = eng_get_output ? {3'b0, src1, 14'b0} :
                          (eng_ins_in ? instr[23:0] : '0);
  assign eng_din_1      = load_fire ? in_d1 : '0;
  assign eng_din_2      = load_fire ? in_d2 : '0;

  // Read-before-write: a word rewritten while being fetched returns its old value.
  always_ff @(posedge clk) begin
    if (prog_we)
      prog_mem[prog_addr] <= prog_data;
    if (state == S_FETCH)
      instr <= prog_mem[pc];
  end

  // Entries age one slot per cycle; an entry blocks readers while its count is non-zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      trk_vld <= '0;
      trk_dst <= '0;
      trk_cnt <= '0;
    end else begin
      trk_vld[0] <= push_en;
      trk_dst[0] <= dst;
      trk_cnt[0] <= push_cnt;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        trk_vld[i] <= trk_vld[i-1] && (trk_cnt[i-1] > 4'd1);
        trk_dst[i] <= trk_dst[i-1];
        trk_cnt[i] <= trk_cnt[i-1] - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      pc        <= '0;
      rd_cnt    <= '0;
      err       <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_d1    <= '0;
      out_d2    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            pc    <= start_pc;
            err   <= 1'b0;
            state <= S_FETCH;
          end
        end
        S_FETCH: state <= S_ISSUE;
        S_ISSUE: begin
          if (!hazard) begin
            if (is_read) begin
              rd_cnt <= RD_CNT;
              state  <= S_READ_WAIT;
            end else if (is_halt) begin
              done  <= 1'b1;
              state <= S_IDLE;
            end else if (is_load) begin
              state <= S_WAIT_IN;
            end
          end
        end
        S_WAIT_IN: ;
        S_READ_WAIT: begin
          if (rd_cnt == 3'd0) begin
            out_d1    <= eng_dout_1;
            out_d2    <= eng_dout_2;
            out_valid <= 1'b1;
            state     <= S_OUT_HOLD;
          end else begin
            rd_cnt <= rd_cnt - 3'd1;
          end
        end
        S_OUT_HOLD: begin
          if (out_ready)
            out_valid <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase

      if (adv) begin
        if (pc_last) begin
          err   <= 1'b1;
          state <= S_IDLE;
        end else begin
          pc    <= pc + 1'b1;
          state <= S_FETCH;
        end
      end
    end
  end

endmodule
